// File: rtl/tcam_pipelined.sv
// Ternary CAM with per-entry care mask, two-stage lookup pipeline and a single-commit write FSM.
// Optional per-entry saturating hit counters are built when TCAM_HIT_COUNT_EN is defined.
module tcam_pipelined #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      write_addr,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic [DATA_WIDTH-1:0]      write_mask,
    input  logic                       write_delete,
    input  logic                       write_enable,
    output logic                       write_busy,
    input  logic [DATA_WIDTH-1:0]      lookup_data,
    input  logic [TAG_WIDTH-1:0]       lookup_tag,
    input  logic                       lookup_valid,
    output logic                       lookup_ready,
    output logic                       result_valid,
    output logic [TAG_WIDTH-1:0]       result_tag,
    output logic                       result_hit,
    output logic [ADDR_WIDTH-1:0]      result_addr,
    output logic [(2**ADDR_WIDTH)-1:0] result_many,
    output logic [ADDR_WIDTH:0]        entry_count
`ifdef TCAM_HIT_COUNT_EN
    ,
    input  logic [ADDR_WIDTH-1:0]      hit_cnt_addr,
    output logic [15:0]                hit_cnt_data
`endif
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] COUNT_MAX  = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } wr_state_t;

    wr_state_t                 state_r;
    wr_state_t                 state_next_s;
    logic                      capture_s;
    logic                      commit_s;

    logic [ADDR_WIDTH-1:0]     wr_addr_r;
    logic [DATA_WIDTH-1:0]     wr_key_r;
    logic [DATA_WIDTH-1:0]     wr_mask_r;
    logic                      wr_delete_r;

    logic [DEPTH-1:0]          valid_r;
    logic [DATA_WIDTH-1:0]     key_r  [DEPTH];
    logic [DATA_WIDTH-1:0]     mask_r [DEPTH];
    logic [ADDR_WIDTH:0]       count_next_s;

    logic                      accept_s;
    logic [DEPTH-1:0]          match_s;
    logic                      s1_valid_r;
    logic [DEPTH-1:0]          s1_match_r;
    logic [TAG_WIDTH-1:0]      s1_tag_r;
    logic [ADDR_WIDTH-1:0]     s1_enc_s;

    // Lowest set bit wins; an empty vector encodes to index 0.
    function automatic logic [ADDR_WIDTH-1:0] lowest_index(input logic [DEPTH-1:0] vec);
        logic [ADDR_WIDTH-1:0] idx;
        idx = {ADDR_WIDTH{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[ADDR_WIDTH-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign write_busy   = (state_r == ST_COMMIT);
    assign lookup_ready = ~write_busy;
    assign accept_s     = lookup_valid & lookup_ready;
    assign s1_enc_s     = lowest_index(s1_match_r);

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Write FSM next state: capture in IDLE, apply on the edge leaving COMMIT.
    always_comb begin
        state_next_s = state_r;
        capture_s    = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (write_enable) begin
                    state_next_s = ST_COMMIT;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                state_next_s = ST_IDLE;
                commit_s     = 1'b1;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pending write request held across the COMMIT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_r   <= {ADDR_WIDTH{1'b0}};
            wr_key_r    <= {DATA_WIDTH{1'b0}};
            wr_mask_r   <= {DATA_WIDTH{1'b0}};
            wr_delete_r <= 1'b0;
        end else if (capture_s) begin
            wr_addr_r   <= write_addr;
            wr_key_r    <= write_data & write_mask;
            wr_mask_r   <= write_mask;
            wr_delete_r <= write_delete;
        end
    end

    // Entry storage; only the commit edge writes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                key_r[i]  <= {DATA_WIDTH{1'b0}};
                mask_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (commit_s) begin
            if (wr_delete_r) begin
                valid_r[wr_addr_r] <= 1'b0;
            end else begin
                valid_r[wr_addr_r] <= 1'b1;
                key_r[wr_addr_r]   <= wr_key_r;
                mask_r[wr_addr_r]  <= wr_mask_r;
            end
        end
    end

    // Occupancy follows slot transitions only, so overwrites and double deletes leave it alone.
    always_comb begin
        count_next_s = entry_count;
        if (commit_s) begin
            if (wr_delete_r) begin
                if (valid_r[wr_addr_r] && (entry_count != COUNT_ZERO)) begin
                    count_next_s = entry_count - COUNT_ONE;
                end else begin
                    count_next_s = entry_count;
                end
            end else begin
                if (!valid_r[wr_addr_r] && (entry_count != COUNT_MAX)) begin
                    count_next_s = entry_count + COUNT_ONE;
                end else begin
                    count_next_s = entry_count;
                end
            end
        end else begin
            count_next_s = entry_count;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_count <= COUNT_ZERO;
        end else begin
            entry_count <= count_next_s;
        end
    end

    // Parallel ternary compare of the search key against every entry.
    always_comb begin
        match_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = valid_r[i] &&
                         (((lookup_data ^ key_r[i]) & mask_r[i]) == {DATA_WIDTH{1'b0}});
        end
    end

    // Stage 1: match vector and tag at the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_match_r <= {DEPTH{1'b0}};
            s1_tag_r   <= {TAG_WIDTH{1'b0}};
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_match_r <= match_s;
                s1_tag_r   <= lookup_tag;
            end
        end
    end

    // Stage 2: priority encode; result fields hold between results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid <= 1'b0;
            result_tag   <= {TAG_WIDTH{1'b0}};
            result_hit   <= 1'b0;
            result_addr  <= {ADDR_WIDTH{1'b0}};
            result_many  <= {DEPTH{1'b0}};
        end else begin
            result_valid <= s1_valid_r;
            if (s1_valid_r) begin
                result_tag  <= s1_tag_r;
                result_hit  <= |s1_match_r;
                result_addr <= s1_enc_s;
                result_many <= s1_match_r;
            end
        end
    end

`ifdef TCAM_HIT_COUNT_EN
    logic [15:0] hit_cnt_r [DEPTH];

    // Per-entry saturating hit counters; a commit to the entry takes priority over a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hit_cnt_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_s && (wr_addr_r == i[ADDR_WIDTH-1:0])) begin
                    hit_cnt_r[i] <= 16'h0000;
                end else if (s1_valid_r && (|s1_match_r) && (s1_enc_s == i[ADDR_WIDTH-1:0])
                             && (hit_cnt_r[i] != 16'hFFFF)) begin
                    hit_cnt_r[i] <= hit_cnt_r[i] + 16'h0001;
                end
            end
        end
    end

    // Registered counter read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_data <= 16'h0000;
        end else begin
            hit_cnt_data <= hit_cnt_r[hit_cnt_addr];
        end
    end
`endif

endmodule

// File: tb/tb_tcam_pipelined.sv
// Self-checking bench for tcam_pipelined: directed vector table, hazard/reset sequences and
// randomized traffic checked every cycle against a transaction-level table model.
module tb_tcam_pipelined;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int TW = 8;
    localparam int DEPTH = 32;
    localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [DW-1:0] Z64 = 64'h0;
    localparam logic [AW-1:0] Z5 = 5'd0;
    localparam logic [TW-1:0] Z8 = 8'h0;
    localparam logic [31:0]   Z32 = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data, write_mask;
    logic write_delete, write_enable, write_busy;
    logic [DW-1:0] lookup_data;
    logic [TW-1:0] lookup_tag;
    logic lookup_valid, lookup_ready;
    logic result_valid, result_hit;
    logic [TW-1:0] result_tag;
    logic [AW-1:0] result_addr;
    logic [DEPTH-1:0] result_many;
    logic [AW:0] entry_count;
`ifdef TCAM_HIT_COUNT_EN
    logic [AW-1:0] hit_cnt_addr;
    logic [15:0] hit_cnt_data;
    logic [15:0] m_hcd;
`endif

    tcam_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .write_addr(write_addr), .write_data(write_data), .write_mask(write_mask),
        .write_delete(write_delete), .write_enable(write_enable), .write_busy(write_busy),
        .lookup_data(lookup_data), .lookup_tag(lookup_tag), .lookup_valid(lookup_valid),
        .lookup_ready(lookup_ready), .result_valid(result_valid), .result_tag(result_tag),
        .result_hit(result_hit), .result_addr(result_addr), .result_many(result_many),
        .entry_count(entry_count)
`ifdef TCAM_HIT_COUNT_EN
        , .hit_cnt_addr(hit_cnt_addr), .hit_cnt_data(hit_cnt_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: table contents, occupancy, pending write, two-deep result delay.
    typedef struct {
        bit v;
        logic [TW-1:0] tag;
        bit hit;
        logic [AW-1:0] addr;
        logic [DEPTH-1:0] many;
    } res_t;

    bit            m_valid [DEPTH];
    logic [DW-1:0] m_key   [DEPTH];
    logic [DW-1:0] m_mask  [DEPTH];
    int unsigned   m_hits  [DEPTH];
    int            m_count;
    bit            m_busy;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data, p_mask;
    bit            p_del;
    res_t          m_s1, m_out;
    bit            m_rv;

    typedef enum logic [1:0] {OP_RST, OP_WR, OP_DEL, OP_LK} op_t;
    typedef struct {
        op_t op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
        logic [TW-1:0] tag;
        logic hit;
        logic [AW-1:0] raddr;
        logic [31:0] many;
        int count;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(op_t op, logic [AW-1:0] a, logic [DW-1:0] d, logic [DW-1:0] m,
                                logic [TW-1:0] t, logic h, logic [AW-1:0] ra,
                                logic [31:0] many, int cnt);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.mask = m; v.tag = t;
        v.hit = h; v.raddr = ra; v.many = many; v.count = cnt;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0; m_key[i] = Z64; m_mask[i] = Z64; m_hits[i] = 0;
        end
        m_count = 0; m_busy = 1'b0; m_rv = 1'b0;
        m_s1 = '{1'b0, Z8, 1'b0, Z5, Z32};
        m_out = '{1'b0, Z8, 1'b0, Z5, Z32};
`ifdef TCAM_HIT_COUNT_EN
        m_hcd = 16'h0;
`endif
    endtask

    function automatic res_t model_lookup(input logic [DW-1:0] d, input logic [TW-1:0] t);
        res_t r;
        r = '{1'b0, t, 1'b0, Z5, Z32};
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && (((d ^ m_key[i]) & m_mask[i]) == Z64)) begin
                r.many[i] = 1'b1;
                if (!r.hit) begin
                    r.hit = 1'b1;
                    r.addr = AW'(i);
                end
            end
        end
        return r;
    endfunction

    task automatic check_outputs();
        check("write_busy", 64'(write_busy), 64'(m_busy));
        check("lookup_ready", 64'(lookup_ready), 64'(!m_busy));
        check("entry_count", 64'(entry_count), 64'(m_count));
        check("result_valid", 64'(result_valid), 64'(m_rv));
        check("result_tag", 64'(result_tag), 64'(m_out.tag));
        check("result_hit", 64'(result_hit), 64'(m_out.hit));
        check("result_addr", 64'(result_addr), 64'(m_out.addr));
        check("result_many", 64'(result_many), 64'(m_out.many));
`ifdef TCAM_HIT_COUNT_EN
        check("hit_cnt_data", 64'(hit_cnt_data), 64'(m_hcd));
`endif
    endtask

    // One clock: inputs were set after the previous falling edge; outputs checked at the next.
    task automatic step();
        res_t e;
        logic we, wdel;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, wm;
`ifdef TCAM_HIT_COUNT_EN
        logic [15:0] hcd_next;
        hcd_next = 16'(m_hits[hit_cnt_addr]);
`endif
        we = write_enable; wa = write_addr; wd = write_data; wm = write_mask; wdel = write_delete;
        e = model_lookup(lookup_data, lookup_tag);
        e.v = lookup_valid && !m_busy;
        @(posedge clk);
        if (m_s1.v && m_s1.hit && (m_hits[m_s1.addr] < 32'd65535)) m_hits[m_s1.addr]++;
        m_rv = m_s1.v;
        if (m_s1.v) m_out = m_s1;
        m_s1 = e;
        if (m_busy) begin
            if (p_del) begin
                if (m_valid[p_addr]) m_count--;
                m_valid[p_addr] = 1'b0;
            end else begin
                if (!m_valid[p_addr]) m_count++;
                m_valid[p_addr] = 1'b1;
                m_key[p_addr] = p_data & p_mask;
                m_mask[p_addr] = p_mask;
            end
            m_hits[p_addr] = 0;
            m_busy = 1'b0;
        end else if (we) begin
            p_addr = wa; p_data = wd; p_mask = wm; p_del = wdel;
            m_busy = 1'b1;
        end
`ifdef TCAM_HIT_COUNT_EN
        m_hcd = hcd_next;
`endif
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] m, input logic del);
        write_enable = 1'b1; write_addr = a; write_data = d; write_mask = m; write_delete = del;
        step();
        write_enable = 1'b0;
        step();
    endtask

    task automatic do_lookup(input logic [DW-1:0] d, input logic [TW-1:0] t);
        lookup_valid = 1'b1; lookup_data = d; lookup_tag = t;
        step();
        lookup_valid = 1'b0;
        step();
    endtask

    // Reset pulse between clock edges while a write is pending and a lookup is in flight.
    task automatic do_reset();
        write_enable = 1'b1; write_addr = 5'd9; write_data = 64'h1; write_mask = ONES;
        write_delete = 1'b0;
        lookup_valid = 1'b1; lookup_data = 64'h1234; lookup_tag = 8'hEE;
        step();
        write_enable = 1'b0; lookup_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_busy", 64'(write_busy), 64'h0);
        check("rst_count", 64'(entry_count), 64'h0);
        check("rst_rvalid", 64'(result_valid), 64'h0);
        rst = 1'b0;
        step();
        check("rst_rvalid_c1", 64'(result_valid), 64'h0);
        step();
        check("rst_rvalid_c2", 64'(result_valid), 64'h0);
    endtask

    initial begin
        write_enable = 1'b0; write_addr = Z5; write_data = Z64; write_mask = Z64;
        write_delete = 1'b0; lookup_valid = 1'b0; lookup_data = Z64; lookup_tag = Z8;
`ifdef TCAM_HIT_COUNT_EN
        hit_cnt_addr = Z5;
`endif
        model_reset();

        vecs.push_back(mk(OP_RST, Z5, Z64, Z64, Z8, 1'b0, Z5, Z32, 0));
        vecs.push_back(mk(OP_WR, 5'd3, 64'h1234, ONES, Z8, 1'b0, Z5, Z32, 1));
        vecs.push_back(mk(OP_LK, Z5, 64'h1234, Z64, 8'hA5, 1'b1, 5'd3, 32'h8, 1));
        vecs.push_back(mk(OP_LK, Z5, 64'h1235, Z64, 8'h3C, 1'b0, Z5, Z32, 1));
        vecs.push_back(mk(OP_WR, 5'd5, 64'hDEAD, Z64, Z8, 1'b0, Z5, Z32, 2));
        vecs.push_back(mk(OP_WR, 5'd2, 64'hFF, ONES, Z8, 1'b0, Z5, Z32, 3));
        vecs.push_back(mk(OP_LK, Z5, 64'hFF, Z64, 8'h11, 1'b1, 5'd2, 32'h24, 3));
        vecs.push_back(mk(OP_LK, Z5, 64'h0, Z64, 8'h22, 1'b1, 5'd5, 32'h20, 3));
        vecs.push_back(mk(OP_LK, Z5, 64'h1234, Z64, 8'h33, 1'b1, 5'd3, 32'h28, 3));
        vecs.push_back(mk(OP_WR, 5'd7, 64'hABCD, 64'hFF00, Z8, 1'b0, Z5, Z32, 4));
        vecs.push_back(mk(OP_LK, Z5, 64'hAB77, Z64, 8'h44, 1'b1, 5'd5, 32'hA0, 4));
        vecs.push_back(mk(OP_DEL, 5'd5, Z64, Z64, Z8, 1'b0, Z5, Z32, 3));
        vecs.push_back(mk(OP_LK, Z5, 64'hAB77, Z64, 8'h55, 1'b1, 5'd7, 32'h80, 3));
        vecs.push_back(mk(OP_LK, Z5, 64'h1235, Z64, 8'h66, 1'b0, Z5, Z32, 3));
        vecs.push_back(mk(OP_RST, Z5, Z64, Z64, Z8, 1'b0, Z5, Z32, 0));
        vecs.push_back(mk(OP_LK, Z5, 64'h1234, Z64, 8'h67, 1'b0, Z5, Z32, 0));
        vecs.push_back(mk(OP_LK, Z5, 64'hAB77, Z64, 8'h68, 1'b0, Z5, Z32, 0));
        vecs.push_back(mk(OP_LK, Z5, 64'h1, Z64, 8'h69, 1'b0, Z5, Z32, 0));
        vecs.push_back(mk(OP_WR, 5'd0, 64'h10, ONES, Z8, 1'b0, Z5, Z32, 1));
        vecs.push_back(mk(OP_WR, 5'd1, 64'h20, ONES, Z8, 1'b0, Z5, Z32, 2));
        vecs.push_back(mk(OP_WR, 5'd1, 64'h30, ONES, Z8, 1'b0, Z5, Z32, 2));
        vecs.push_back(mk(OP_DEL, 5'd1, Z64, Z64, Z8, 1'b0, Z5, Z32, 1));
        vecs.push_back(mk(OP_DEL, 5'd1, Z64, Z64, Z8, 1'b0, Z5, Z32, 1));
        vecs.push_back(mk(OP_LK, Z5, 64'h30, Z64, 8'h77, 1'b0, Z5, Z32, 1));
        vecs.push_back(mk(OP_LK, Z5, 64'h10, Z64, 8'h88, 1'b1, 5'd0, 32'h1, 1));

        repeat (2) @(negedge clk);
        check("init_busy", 64'(write_busy), 64'h0);
        check("init_count", 64'(entry_count), 64'h0);
        check("init_rvalid", 64'(result_valid), 64'h0);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            case (vecs[k].op)
                OP_RST: do_reset();
                OP_WR:  do_write(vecs[k].addr, vecs[k].data, vecs[k].mask, 1'b0);
                OP_DEL: do_write(vecs[k].addr, Z64, Z64, 1'b1);
                default: begin
                    do_lookup(vecs[k].data, vecs[k].tag);
                    check("vec_rvalid", 64'(result_valid), 64'h1);
                    check("vec_tag", 64'(result_tag), 64'(vecs[k].tag));
                    check("vec_hit", 64'(result_hit), 64'(vecs[k].hit));
                    check("vec_addr", 64'(result_addr), 64'(vecs[k].raddr));
                    check("vec_many", 64'(result_many), 64'(vecs[k].many));
                end
            endcase
            check("vec_count", 64'(entry_count), 64'(vecs[k].count));
        end

        // Write hazard with lookup_valid held high throughout.
        write_enable = 1'b1; write_addr = 5'd9; write_data = 64'h5555; write_mask = ONES;
        write_delete = 1'b0;
        lookup_valid = 1'b1; lookup_data = 64'h5555; lookup_tag = 8'hC1;
        step();
        check("hz_busy_1", 64'(write_busy), 64'h1);
        check("hz_ready_1", 64'(lookup_ready), 64'h0);
        write_addr = 5'd10; write_data = 64'h6666; lookup_tag = 8'hC2;
        step();
        check("hz_ready_2", 64'(lookup_ready), 64'h1);
        check("hz_old_tag", 64'(result_tag), 64'hC1);
        check("hz_old_hit", 64'(result_hit), 64'h0);
        write_enable = 1'b0; lookup_tag = 8'hC3;
        step();
        check("hz_no_result", 64'(result_valid), 64'h0);
        lookup_valid = 1'b0;
        step();
        check("hz_new_tag", 64'(result_tag), 64'hC3);
        check("hz_new_hit", 64'(result_hit), 64'h1);
        check("hz_new_addr", 64'(result_addr), 64'd9);
        check("hz_count", 64'(entry_count), 64'd2);
        do_lookup(64'h6666, 8'hC4);
        check("hz_ignored_wr", 64'(result_hit), 64'h0);

`ifdef TCAM_HIT_COUNT_EN
        do_reset();
        do_write(5'd3, 64'h1234, ONES, 1'b0);
        for (int j = 0; j < 3; j++) do_lookup(64'h1234, 8'(j));
        hit_cnt_addr = 5'd3;
        step();
        check("hitcnt_3", 64'(hit_cnt_data), 64'd3);
        do_write(5'd3, 64'h1234, ONES, 1'b0);
        step();
        check("hitcnt_clr", 64'(hit_cnt_data), 64'd0);
`endif

        for (int c = 0; c < 3000; c++) begin
            write_enable = ($urandom_range(0, 3) == 0);
            write_addr = AW'($urandom_range(0, 11));
            write_data = 64'($urandom_range(0, 15));
            case ($urandom_range(0, 4))
                0: write_mask = ONES;
                1: write_mask = Z64;
                2: write_mask = 64'hF;
                3: write_mask = 64'hC;
                default: write_mask = 64'h3;
            endcase
            write_delete = ($urandom_range(0, 3) == 0);
            lookup_valid = ($urandom_range(0, 9) < 7);
            lookup_data = 64'($urandom_range(0, 15)) |
                          (($urandom_range(0, 7) == 0) ? 64'h100_0000_0000 : Z64);
            lookup_tag = TW'($urandom);
`ifdef TCAM_HIT_COUNT_EN
            hit_cnt_addr = AW'($urandom_range(0, 11));
`endif
            if (c == 1500) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
